reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Central reset controller for the NeoGeo core.
- Arbitrates reset requesters: power-on, ROM loading, user/OSD reset and watchdog expiry.
- Asserts the 68k, Z80 and system-peripheral resets for a frame-counted hold time, then releases them in order: 68k/system first, Z80 after a further frame-counted delay.
- Sits between the framework reset and the CPU/IO blocks. Latches the cause of the last reset for the OSD/debug readout.

Parameters:
- HOLD_FRAMES, 8: frame ticks (rising edges of WDCLK) all resets stay asserted; legal 1..255.
- Z80_DELAY, 2: further frame ticks the Z80 stays in reset after the 68k is released; legal 0..255.

Ports:
- CLK  in  1  core clock.
- nRST  in  1  reset, asynchronous, active-low.
- WDCLK  in  1  frame tick level (vblank-derived), synchronous to CLK; rising edges counted.
- REQ_LOAD  in  1  level; ROM load in progress; holds reset while high.
- REQ_USER  in  1  user/OSD reset; rising edge triggers.
- REQ_WD  in  1  watchdog expiry, active-high; rising edge triggers.
- nRESET_68K  out  1  68k reset, active-low.
- nRESET_SYS  out  1  peripheral/IO reset, active-low.
- nRESET_Z80  out  1  Z80 reset, active-low.
- CAUSE  out  2  last reset cause: 0=POR, 1=LOAD, 2=USER, 3=WD.
- BUSY  out  1  high whenever state is not RUN.

Behaviour:
- All outputs are registered.
- Asynchronous reset (nRST low):
  - state=HOLD, counter=0, CAUSE=0.
  - nRESET_68K/SYS/Z80=0, BUSY=1.
  - Edge-detect registers cleared to 0.
- WDCLK edge: registered copy WDCLK_D; tick = WDCLK & ~WDCLK_D.
  - The first tick can occur the cycle after WDCLK first rises following reset deassertion.
- Edge detection for REQ_USER and REQ_WD works the same way (REQ_x & ~REQ_x_D).
- req = REQ_LOAD | user_edge | wd_edge.
- Priority when several are true in one cycle: LOAD > USER > WD. The winner's code is written to CAUSE.
- States:
  - HOLD: all three resets low; counter increments on tick.
    - When counter reaches HOLD_FRAMES-1 and a tick occurs (no req): go to STAGGER and clear counter. nRESET_68K=1 and nRESET_SYS=1 take effect from that edge.
    - If Z80_DELAY==0, go directly to RUN instead, and release all three on the same edge.
  - STAGGER: 68k/SYS released, Z80 held; counter increments on tick.
    - At counter==Z80_DELAY-1 with a tick: go to RUN, nRESET_Z80=1.
  - RUN: all released, BUSY=0, counter held at 0.
- Any req in any state (including HOLD and STAGGER):
  - Next state HOLD, counter cleared to 0, CAUSE updated.
  - All three resets 0 after that edge (1-cycle latency from the sampled edge).
- req in the same cycle as a tick: req wins; counter = 0, no increment.
- REQ_LOAD held high keeps the block in HOLD with counter pinned at 0. Hold time is counted from the first tick after REQ_LOAD falls.
- REQ_WD / REQ_USER held high do not retrigger. Only new rising edges count. This prevents a lock-up when the watchdog output is itself cleared by our reset.
- CAUSE changes only on an accepted req or on nRST. It is stable in RUN.
- Counter is 8 bits. It never wraps, because it is compared and cleared before 255.

Decomposition:
- Shared package neogeo_rst_pkg:
  - state enum {HOLD, STAGGER, RUN} (2-bit).
  - CAUSE codes CAUSE_POR/LOAD/USER/WD.
  - Counter width constant RST_CW=8.
- One sub-module, rise_detect: 1-bit registered rising-edge detector with async active-low clear, CLK/nRST. Instantiated three times (WDCLK, REQ_USER, REQ_WD).

Test Plan:
- POR, HOLD_FRAMES=8, Z80_DELAY=2, WDCLK toggling:
  - nRESET_68K/SYS rise on the edge of the 8th tick.
  - nRESET_Z80 rises on the edge of the 10th tick.
  - BUSY falls with Z80; CAUSE=0.
- In RUN, REQ_WD pulses 1 cycle:
  - All resets 0 the next cycle, CAUSE=3.
  - Release after 8 more ticks; Z80 release after 2 more.
  - REQ_WD held high afterwards: no second reset.
- REQ_LOAD high for 20 ticks:
  - Resets held low throughout, CAUSE=1.
  - After fall, 68k released on the 8th subsequent tick.
- In STAGGER after 1 tick, REQ_USER rising edge:
  - nRESET_68K returns to 0, CAUSE=2, counter restarts.
  - Full 8+2 tick sequence repeats.
- REQ_USER and REQ_WD edges in the same cycle as a tick: CAUSE=2 and counter=0. Z80_DELAY=0 build: all three resets release on the same edge.
- nRST asserted mid-STAGGER (asynchronous, between clock edges): outputs go low immediately; CAUSE=0, state HOLD.

Source files
------------

// File: rtl/neogeo_rst_pkg.sv
// Shared definitions for the NeoGeo reset sequencer: FSM state codes,
// reset-cause codes and the frame counter width.
package neogeo_rst_pkg;

  // Frame counter width; compared and cleared long before it could wrap.
  localparam int RST_CW = 8;

  // Sequencer state encoding (kept as plain constants for legacy tooling).
  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_STAGGER = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // Last-reset cause codes as seen on the OSD/debug readout.
  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOAD = 2'd1;
  localparam logic [1:0] CAUSE_USER = 2'd2;
  localparam logic [1:0] CAUSE_WD   = 2'd3;

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector. The delayed copy is registered; the edge
// flag is the live input against that copy, so it is valid in the cycle
// the input is first seen high.
module rise_detect (
  input  logic CLK,
  input  logic nRST,
  input  logic din,
  output logic rise
);

  logic din_d_reg;

  // Keep a one-cycle-old copy of the input; cleared so a high input right
  // after reset release still counts as a fresh edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      din_d_reg <= 1'b0;
    end else begin
      din_d_reg <= din;
    end
  end

  assign rise = din & ~din_d_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller for the NeoGeo core. Arbitrates power-on, ROM
// load, user/OSD and watchdog reset requests, holds all CPU/IO resets for
// HOLD_FRAMES frame ticks, then releases 68k/system first and the Z80
// Z80_DELAY ticks later. The cause of the last accepted reset is latched.
module reset_sequencer
  import neogeo_rst_pkg::*;
#(
  parameter int HOLD_FRAMES = 8,  // 1..255
  parameter int Z80_DELAY   = 2   // 0..255
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       WDCLK,
  input  logic       REQ_LOAD,
  input  logic       REQ_USER,
  input  logic       REQ_WD,
  output logic       nRESET_68K,
  output logic       nRESET_SYS,
  output logic       nRESET_Z80,
  output logic [1:0] CAUSE,
  output logic       BUSY
);

  // Terminal counts: the transition fires on the tick seen at count N-1.
  localparam logic [RST_CW-1:0] HOLD_LAST = RST_CW'(HOLD_FRAMES - 1);
  localparam logic [RST_CW-1:0] Z80_LAST  =
    RST_CW'((Z80_DELAY > 0) ? (Z80_DELAY - 1) : 0);

  logic              tick;
  logic              user_edge;
  logic              wd_edge;
  logic              req;

  logic [1:0]        state_reg, state_next;
  logic [RST_CW-1:0] cnt_reg, cnt_next;
  logic [1:0]        cause_reg, cause_next;
  logic              n68k_reg, nz80_reg, busy_reg;

  rise_detect u_tick_det (
    .CLK  (CLK),
    .nRST (nRST),
    .din  (WDCLK),
    .rise (tick)
  );

  rise_detect u_user_det (
    .CLK  (CLK),
    .nRST (nRST),
    .din  (REQ_USER),
    .rise (user_edge)
  );

  // Edge-only so a watchdog held high by our own reset cannot lock us up.
  rise_detect u_wd_det (
    .CLK  (CLK),
    .nRST (nRST),
    .din  (REQ_WD),
    .rise (wd_edge)
  );

  // LOAD is a level: it keeps re-requesting and so pins the counter at 0.
  assign req = REQ_LOAD | user_edge | wd_edge;

  // Next-state, counter and cause selection; a request always beats a tick.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cause_next = cause_reg;
    if (req) begin
      state_next = ST_HOLD;
      cnt_next   = '0;
      if (REQ_LOAD) begin
        cause_next = CAUSE_LOAD;
      end else if (user_edge) begin
        cause_next = CAUSE_USER;
      end else begin
        cause_next = CAUSE_WD;
      end
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (tick) begin
            if (cnt_reg == HOLD_LAST) begin
              state_next = (Z80_DELAY == 0) ? ST_RUN : ST_STAGGER;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + RST_CW'(1);
            end
          end
        end
        ST_STAGGER: begin
          if (tick) begin
            if (cnt_reg == Z80_LAST) begin
              state_next = ST_RUN;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + RST_CW'(1);
            end
          end
        end
        ST_RUN: begin
          cnt_next = '0;
        end
        default: begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, counter, cause and registered outputs (decoded from next state
  // so each reset line changes on the same edge as the state).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= ST_HOLD;
      cnt_reg   <= '0;
      cause_reg <= CAUSE_POR;
      n68k_reg  <= 1'b0;
      nz80_reg  <= 1'b0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cause_reg <= cause_next;
      n68k_reg  <= (state_next != ST_HOLD);
      nz80_reg  <= (state_next == ST_RUN);
      busy_reg  <= (state_next != ST_RUN);
    end
  end

  assign nRESET_68K = n68k_reg;
  assign nRESET_SYS = n68k_reg;
  assign nRESET_Z80 = nz80_reg;
  assign CAUSE      = cause_reg;
  assign BUSY       = busy_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Two instances share stimulus:
// u_dut (HOLD_FRAMES=8, Z80_DELAY=2) and u_dut0 (HOLD_FRAMES=8, Z80_DELAY=0).
module tb_reset_sequencer;

  logic       CLK;
  logic       nRST;
  logic       WDCLK;
  logic       REQ_LOAD;
  logic       REQ_USER;
  logic       REQ_WD;
  logic       nRESET_68K, nRESET_SYS, nRESET_Z80, BUSY;
  logic [1:0] CAUSE;
  logic       b_68k, b_sys, b_z80, b_busy;
  logic [1:0] b_cause;

  int checks;
  int errors;

  reset_sequencer #(.HOLD_FRAMES(8), .Z80_DELAY(2)) u_dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .WDCLK      (WDCLK),
    .REQ_LOAD   (REQ_LOAD),
    .REQ_USER   (REQ_USER),
    .REQ_WD     (REQ_WD),
    .nRESET_68K (nRESET_68K),
    .nRESET_SYS (nRESET_SYS),
    .nRESET_Z80 (nRESET_Z80),
    .CAUSE      (CAUSE),
    .BUSY       (BUSY)
  );

  reset_sequencer #(.HOLD_FRAMES(8), .Z80_DELAY(0)) u_dut0 (
    .CLK        (CLK),
    .nRST       (nRST),
    .WDCLK      (WDCLK),
    .REQ_LOAD   (REQ_LOAD),
    .REQ_USER   (REQ_USER),
    .REQ_WD     (REQ_WD),
    .nRESET_68K (b_68k),
    .nRESET_SYS (b_sys),
    .nRESET_Z80 (b_z80),
    .CAUSE      (b_cause),
    .BUSY       (b_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       load;
    logic       user;
    logic       wd;
    logic       tk;
    logic       e68;
    logic       ez80;
    logic       ebusy;
    logic [1:0] ecause;
    logic       eb;     // all three resets of the Z80_DELAY=0 instance
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic l, input logic u, input logic w, input logic t,
                     input logic e68, input logic ez80, input logic ebusy,
                     input logic [1:0] ec, input logic eb);
    vec_t v;
    v.load = l; v.user = u; v.wd = w; v.tk = t;
    v.e68 = e68; v.ez80 = ez80; v.ebusy = ebusy; v.ecause = ec; v.eb = eb;
    vecs.push_back(v);
  endtask

  // Ticks counted from HOLD with counter 0: 68k/SYS (and all of the
  // Z80_DELAY=0 instance) release on tick 8, Z80 on tick 10.
  task automatic add_ticks(input int n, input logic u, input logic w,
                           input logic [1:0] c);
    for (int i = 1; i <= n; i++) begin
      add(1'b0, u, w, 1'b1, (i >= 8), (i >= 10), (i < 10), c, (i >= 8));
    end
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic pulse_tick();
    WDCLK = 1'b1;
    @(posedge CLK); #1;
    WDCLK = 1'b0;
    @(posedge CLK); #1;
  endtask

  function automatic logic [15:0] outs_a();
    return {11'd0, nRESET_68K, nRESET_SYS, nRESET_Z80, BUSY, 1'b0} | {14'd0, CAUSE} << 0;
  endfunction

  logic [15:0] act_v, exp_v;

  initial begin
    checks   = 0;
    errors   = 0;
    nRST     = 1'b0;
    WDCLK    = 1'b0;
    REQ_LOAD = 1'b0;
    REQ_USER = 1'b0;
    REQ_WD   = 1'b0;

    // Phase 1: power-on sequence
    add_ticks(10, 1'b0, 1'b0, 2'd0);
    // Phase 2: watchdog edge, then held high through a full sequence
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    add_ticks(13, 1'b0, 1'b1, 2'd3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
    // Phase 3: ROM load held for 20 ticks, then a full sequence
    for (int i = 0; i < 20; i++) begin
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    add_ticks(10, 1'b0, 1'b0, 2'd1);
    // LOAD beats USER and WD in the same cycle
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    // Phase 4: user reset while in STAGGER after one tick
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    add_ticks(9, 1'b0, 1'b0, 2'd3);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    add_ticks(10, 1'b0, 1'b0, 2'd2);
    // Phase 5: USER and WD edges coincide with a tick; tick must not count
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    add_ticks(10, 1'b0, 1'b0, 2'd2);

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("por_a", {8'd0, nRESET_68K, nRESET_SYS, nRESET_Z80, BUSY, 2'b00, CAUSE},
          {8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0});
    check("por_b", {8'd0, b_68k, b_sys, b_z80, b_busy, 2'b00, b_cause},
          {8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0});
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Table: each vector is one cycle of stimulus plus one idle cycle
    for (int k = 0; k < vecs.size(); k++) begin
      REQ_LOAD = vecs[k].load;
      REQ_USER = vecs[k].user;
      REQ_WD   = vecs[k].wd;
      WDCLK    = vecs[k].tk;
      @(posedge CLK); #1;
      WDCLK = 1'b0;
      @(posedge CLK); #1;
      act_v = {7'd0, nRESET_68K, nRESET_SYS, nRESET_Z80, BUSY, CAUSE, b_68k, b_sys, b_z80};
      exp_v = {7'd0, vecs[k].e68, vecs[k].e68, vecs[k].ez80, vecs[k].ebusy,
               vecs[k].ecause, vecs[k].eb, vecs[k].eb, vecs[k].eb};
      check($sformatf("vec%0d", k), act_v, exp_v);
    end
    REQ_LOAD = 1'b0; REQ_USER = 1'b0; REQ_WD = 1'b0;

    // One-cycle latency from a 1-cycle watchdog pulse while in RUN
    REQ_WD = 1'b1;
    @(negedge CLK);
    check("wd_pre_edge", {15'd0, nRESET_68K}, 16'd1);
    @(posedge CLK); #1;
    REQ_WD = 1'b0;
    check("wd_post_edge", {10'd0, nRESET_68K, nRESET_SYS, nRESET_Z80, BUSY, CAUSE},
          {10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3});

    // Reach STAGGER, then assert nRST between clock edges
    for (int i = 0; i < 9; i++) pulse_tick();
    check("stagger", {13'd0, nRESET_68K, nRESET_Z80, BUSY}, {13'd0, 1'b1, 1'b0, 1'b1});
    #3;
    nRST = 1'b0;
    #1;
    check("async_rst", {10'd0, nRESET_68K, nRESET_SYS, nRESET_Z80, BUSY, CAUSE},
          {10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    // Back in HOLD with counter 0: release on the 8th tick, not earlier
    for (int i = 0; i < 7; i++) pulse_tick();
    check("after_rst_7", {14'd0, nRESET_68K, CAUSE == 2'd0}, {14'd0, 1'b0, 1'b1});
    pulse_tick();
    check("after_rst_8", {13'd0, nRESET_68K, nRESET_Z80, b_z80}, {13'd0, 1'b1, 1'b0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
